// File: rtl/nor_sweep_checker.sv
// Self-test sweeper for a three-stage NOR chain (e=~(a|b), f=~(e|c), g=~(f|d)).
// Drives all 16 vectors, compares e,f,g after a settle delay, and reports mismatches.
module nor_sweep_checker #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE - 1);
  localparam logic [PC_W-1:0] PASS_LAST   = PC_W'(PASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       first_err_vec_q, first_err_vec_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic exp_e, exp_f, exp_g, mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + ERR_W'(1);
  endfunction

  always_comb begin
    exp_e    = ~(vec_q[3] | vec_q[2]);
    exp_f    = ~(exp_e | vec_q[1]);
    exp_g    = ~(exp_f | vec_q[0]);
    mismatch = ({e, f, g} != {exp_e, exp_f, exp_g});

    state_d           = state_q;
    vec_d             = vec_q;
    settle_d          = settle_q;
    pass_cnt_d        = pass_cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;
    pass_d            = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d             = '0;
          pass_cnt_d        = '0;
          err_cnt_d         = '0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
          pass_d            = 1'b0;
          settle_d          = SETTLE_LOAD;
          state_d           = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q == '0) state_d = S_CHECK;
        else                settle_d = settle_q - SC_W'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (!first_err_valid_q) begin
            first_err_vec_d   = vec_q;
            first_err_valid_d = 1'b1;
          end
        end
        // pass is resolved on entry to DONE so it is visible alongside the done pulse
        if (vec_q == 4'd15 && pass_cnt_q == PASS_LAST) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == '0);
        end else begin
          vec_d = vec_q + 4'd1;
          if (vec_q == 4'd15) pass_cnt_d = pass_cnt_q + PC_W'(1);
          settle_d = SETTLE_LOAD;
          state_d  = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      vec_q             <= '0;
      settle_q          <= '0;
      pass_cnt_q        <= '0;
      err_cnt_q         <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      settle_q          <= settle_d;
      pass_cnt_q        <= pass_cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
      pass_q            <= pass_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  assign a               = vec_q[3];
  assign b               = vec_q[2];
  assign c               = vec_q[1];
  assign d               = vec_q[0];
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_vec   = first_err_vec_q;
  assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_nor_sweep_checker.sv
// Bench for nor_sweep_checker: three instances (default, ERR_W=2, PASSES=2) each wrapped
// around a modelled NOR chain with per-vector fault masks; results checked against a sweep model.
module tb_nor_sweep_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_i [3];
  logic [2:0] and_m [3][16];
  logic [2:0] xor_m [3][16];

  wire       busy_o   [3];
  wire       done_o   [3];
  wire       pass_o   [3];
  wire       fvalid_o [3];
  wire [4:0] err_o    [3];
  wire [3:0] fvec_o   [3];
  wire [3:0] vec_o    [3];

  int nchk = 0;
  int nerr = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int EW = (gi == 1) ? 2 : 5;
    localparam int PS = (gi == 2) ? 2 : 1;
    logic a, b, c, d, e, f, g, busy, done, pass, fvalid;
    logic [EW-1:0] err;
    logic [3:0] fvec;
    logic ce, cf, cg;
    assign ce = ~(a | b);
    assign cf = ~(ce | c);
    assign cg = ~(cf | d);
    assign {e, f, g} = ({ce, cf, cg} & and_m[gi][{a, b, c, d}]) ^ xor_m[gi][{a, b, c, d}];

    nor_sweep_checker #(.SETTLE(S), .PASSES(PS), .ERR_W(EW)) u_dut (
      .clk(clk), .rst(rst), .start(start_i[gi]),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err),
      .first_err_vec(fvec), .first_err_valid(fvalid)
    );

    assign busy_o[gi]   = busy;
    assign done_o[gi]   = done;
    assign pass_o[gi]   = pass;
    assign fvalid_o[gi] = fvalid;
    assign err_o[gi]    = 5'(err);
    assign fvec_o[gi]   = fvec;
    assign vec_o[gi]    = {a, b, c, d};
  end

  // Sweep model: good chain from plain arithmetic, faulted observation from the masks.
  function automatic void model(input int k, input int passes, input int errw,
                                output int err, output int fvec, output bit fvalid);
    int maxv;
    maxv = (1 << errw) - 1;
    err = 0; fvec = 0; fvalid = 0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 16; v++) begin
        int av, bv, cv, dv, ee, ff, gg, expv, obs;
        av = (v >> 3) & 1; bv = (v >> 2) & 1; cv = (v >> 1) & 1; dv = v & 1;
        ee = 1 - (av | bv);
        ff = 1 - (ee | cv);
        gg = 1 - (ff | dv);
        expv = ee * 4 + ff * 2 + gg;
        obs = (expv & int'(and_m[k][v])) ^ int'(xor_m[k][v]);
        if (obs != expv) begin
          if (err < maxv) err++;
          if (!fvalid) begin fvec = v; fvalid = 1; end
        end
      end
    end
  endfunction

  task automatic set_masks(input int k, input logic [2:0] am);
    for (int v = 0; v < 16; v++) begin
      and_m[k][v] = am;
      xor_m[k][v] = 3'b000;
    end
  endtask

  task automatic do_run(input int k, input int x1, input int x2,
                        output int nbusy, output int vec_bad, output bit done_ok,
                        output bit pass_v, output int err_v, output int fvec_v, output bit fvalid_v);
    start_i[k] = 1'b1;
    @(posedge clk); #1;
    start_i[k] = 1'b0;
    nbusy = 0; vec_bad = 0;
    while (busy_o[k] === 1'b1 && nbusy < 1000) begin
      if (vec_o[k] !== 4'((nbusy / (S + 1)) % 16)) vec_bad++;
      start_i[k] = (nbusy == x1 || nbusy == x2);
      nbusy++;
      @(posedge clk); #1;
    end
    start_i[k] = 1'b0;
    done_ok  = (done_o[k] === 1'b1);
    pass_v   = pass_o[k];
    err_v    = int'(err_o[k]);
    fvec_v   = int'(fvec_o[k]);
    fvalid_v = fvalid_o[k];
    @(posedge clk); #1;
    if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0) done_ok = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if ({vec_o[k], busy_o[k], done_o[k], pass_o[k], err_o[k], fvec_o[k], fvalid_o[k]} !== 17'd0) begin
        nerr++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", k,
                 {vec_o[k], busy_o[k], done_o[k], pass_o[k], err_o[k], fvec_o[k], fvalid_o[k]});
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_run;
    int nb, vb, ev, fv; bit dk, pv, fvl;
    set_masks(0, 3'b111);
    do_run(0, -1, -1, nb, vb, dk, pv, ev, fv, fvl);
    nchk++; if (nb !== 48) begin nerr++; $display("FAIL clean_busy_len: got %0d expected 48", nb); end
    nchk++; if (vb !== 0) begin nerr++; $display("FAIL clean_vec_seq: got %0d bad expected 0", vb); end
    nchk++; if (dk !== 1'b1) begin nerr++; $display("FAIL clean_done_pulse: got %0b expected 1", dk); end
    nchk++; if (pv !== 1'b1) begin nerr++; $display("FAIL clean_pass: got %0b expected 1", pv); end
    nchk++; if (ev !== 0 || fvl !== 1'b0) begin
      nerr++; $display("FAIL clean_err: got err=%0d valid=%0b expected 0/0", ev, fvl);
    end
    repeat (3) @(posedge clk);
    #1;
    nchk++; if (pass_o[0] !== 1'b1) begin nerr++; $display("FAIL clean_pass_hold: got %0b expected 1", pass_o[0]); end
  endtask

  task automatic test_g_stuck0;
    int nb, vb, ev, fv, me, mf; bit dk, pv, fvl, mv;
    set_masks(0, 3'b110);
    model(0, 1, 5, me, mf, mv);
    do_run(0, -1, -1, nb, vb, dk, pv, ev, fv, fvl);
    nchk++; if (ev !== 5 || ev !== me) begin nerr++; $display("FAIL gstuck_err: got %0d expected 5 (model %0d)", ev, me); end
    nchk++; if (fv !== 0 || fvl !== 1'b1) begin
      nerr++; $display("FAIL gstuck_first: got vec=%0d valid=%0b expected 0/1", fv, fvl);
    end
    nchk++; if (pv !== 1'b0 || dk !== 1'b1) begin
      nerr++; $display("FAIL gstuck_pass_done: got pass=%0b done=%0b expected 0/1", pv, dk);
    end
  endtask

  task automatic test_saturation;
    int nb, vb, ev, fv, me, mf; bit dk, pv, fvl, mv;
    set_masks(1, 3'b011);
    model(1, 1, 2, me, mf, mv);
    do_run(1, -1, -1, nb, vb, dk, pv, ev, fv, fvl);
    nchk++; if (ev !== 3 || ev !== me) begin nerr++; $display("FAIL sat_err: got %0d expected 3 (model %0d)", ev, me); end
    nchk++; if (pv !== 1'b0 || nb !== 48) begin
      nerr++; $display("FAIL sat_pass_len: got pass=%0b busy=%0d expected 0/48", pv, nb);
    end
    nchk++; if (fv !== mf || fvl !== mv) begin
      nerr++; $display("FAIL sat_first: got %0d/%0b expected %0d/%0b", fv, fvl, mf, mv);
    end
  endtask

  task automatic test_two_passes;
    int nb, vb, ev, fv; bit dk, pv, fvl;
    set_masks(2, 3'b110);
    do_run(2, -1, -1, nb, vb, dk, pv, ev, fv, fvl);
    nchk++; if (nb !== 96) begin nerr++; $display("FAIL p2_busy_len: got %0d expected 96", nb); end
    nchk++; if (vb !== 0) begin nerr++; $display("FAIL p2_vec_seq: got %0d bad expected 0", vb); end
    nchk++; if (ev !== 10) begin nerr++; $display("FAIL p2_err: got %0d expected 10", ev); end
    nchk++; if (fv !== 0 || fvl !== 1'b1 || pv !== 1'b0 || dk !== 1'b1) begin
      nerr++; $display("FAIL p2_first_pass: got vec=%0d valid=%0b pass=%0b done=%0b expected 0/1/0/1", fv, fvl, pv, dk);
    end
  endtask

  task automatic test_reset_mid_run;
    int nb, vb, ev, fv, ndone; bit dk, pv, fvl;
    set_masks(0, 3'b110);
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    nchk++; if (vec_o[0] !== 4'd5 || busy_o[0] !== 1'b1) begin
      nerr++; $display("FAIL midrst_pre: got vec=%0d busy=%0b expected 5/1", vec_o[0], busy_o[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if ({vec_o[0], busy_o[0], done_o[0], pass_o[0], err_o[0], fvec_o[0], fvalid_o[0]} !== 17'd0) begin
      nerr++;
      $display("FAIL midrst_outputs: got %h expected 0",
               {vec_o[0], busy_o[0], done_o[0], pass_o[0], err_o[0], fvec_o[0], fvalid_o[0]});
    end
    rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) ndone++;
    end
    nchk++; if (ndone !== 0) begin nerr++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", ndone); end
    set_masks(0, 3'b111);
    do_run(0, -1, -1, nb, vb, dk, pv, ev, fv, fvl);
    nchk++; if (nb !== 48 || vb !== 0 || dk !== 1'b1 || pv !== 1'b1 || ev !== 0 || fvl !== 1'b0) begin
      nerr++; $display("FAIL midrst_rerun: got busy=%0d vbad=%0d done=%0b pass=%0b err=%0d valid=%0b expected 48/0/1/1/0/0",
                       nb, vb, dk, pv, ev, fvl);
    end
  endtask

  task automatic test_extra_start;
    int nb, vb, ev, fv; bit dk, pv, fvl;
    set_masks(0, 3'b111);
    do_run(0, 3, 40, nb, vb, dk, pv, ev, fv, fvl);
    nchk++; if (nb !== 48 || vb !== 0) begin
      nerr++; $display("FAIL xstart_len: got busy=%0d vbad=%0d expected 48/0", nb, vb);
    end
    nchk++; if (dk !== 1'b1 || pv !== 1'b1 || ev !== 0 || fvl !== 1'b0) begin
      nerr++; $display("FAIL xstart_result: got done=%0b pass=%0b err=%0d valid=%0b expected 1/1/0/0", dk, pv, ev, fvl);
    end
  endtask

  task automatic test_random_faults;
    for (int it = 0; it < 6; it++) begin
      int k, ps, ew, nb, vb, ev, fv, me, mf; bit dk, pv, fvl, mv;
      k  = $urandom_range(0, 2);
      ps = (k == 2) ? 2 : 1;
      ew = (k == 1) ? 2 : 5;
      for (int v = 0; v < 16; v++) begin
        and_m[k][v] = 3'b111;
        xor_m[k][v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      model(k, ps, ew, me, mf, mv);
      do_run(k, -1, -1, nb, vb, dk, pv, ev, fv, fvl);
      nchk++; if (nb !== ps * 16 * (S + 1) || dk !== 1'b1) begin
        nerr++; $display("FAIL rand%0d_len: got busy=%0d done=%0b expected %0d/1", it, nb, dk, ps * 16 * (S + 1));
      end
      nchk++; if (ev !== me || pv !== (me == 0)) begin
        nerr++; $display("FAIL rand%0d_err: got err=%0d pass=%0b expected %0d/%0b", it, ev, pv, me, me == 0);
      end
      nchk++; if (fvl !== mv || (mv && fv !== mf)) begin
        nerr++; $display("FAIL rand%0d_first: got %0d/%0b expected %0d/%0b", it, fv, fvl, mf, mv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_i[k] = 1'b0;
      set_masks(k, 3'b111);
    end
    test_reset;
    test_clean_run;
    test_g_stuck0;
    test_saturation;
    test_two_passes;
    test_reset_mid_run;
    test_extra_start;
    test_random_faults;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
